// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the hardwired control sequencer.
// Holds the step-machine state enum, opcode values, IR field positions and the opcode class decoder.
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU, CL_MUL, CL_DIV, CL_MFHI, CL_MFLO, CL_HALT, CL_ILL
  } op_class_t;

  localparam logic [4:0] OP_ALU_LAST = 5'h09;
  localparam logic [4:0] OP_MUL      = 5'h0F;
  localparam logic [4:0] OP_DIV      = 5'h10;
  localparam logic [4:0] OP_MFHI     = 5'h11;
  localparam logic [4:0] OP_MFLO     = 5'h12;
  localparam logic [4:0] OP_HALT     = 5'h1F;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  function automatic op_class_t decode_class(input logic [4:0] op);
    if (op <= OP_ALU_LAST) return CL_ALU;
    case (op)
      OP_MUL:  return CL_MUL;
      OP_DIV:  return CL_DIV;
      OP_MFHI: return CL_MFHI;
      OP_MFLO: return CL_MFLO;
      OP_HALT: return CL_HALT;
      default: return CL_ILL;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_reg_select_decode.sv
// 4-bit register index to 16-bit one-hot select.
// Purely combinational, no handshake.
module reg_select_decode (
  input  logic [3:0]  idx,
  output logic [15:0] onehot
);

  assign onehot = 16'h0001 << idx;

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute step machine (T0..T6) driving every datapath strobe; optional illegal-opcode trap via CTRL_ILLEGAL_TRAP_EN.
// Latency ALU 6, mul/div 7, mfhi/mflo/nop 4 cycles; T1 stalls with Read held until mem_ready.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCin,
  output logic        PCout,
  output logic        IRin,
  output logic        Yin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        MARin,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic [3:0]  ALUop,
  output logic        ALU_MUL,
  output logic        ALU_DIV,
  output logic        IncPC,
  output logic        Read,
  output logic        instr_done,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic        illegal,
`endif
  output logic        halted
);

  state_t      state;
  op_class_t   cls;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  logic        ir_unused;

  assign cls       = decode_class(ir[OPC_MSB:OPC_LSB]);
  assign ir_unused = ^ir[RC_LSB-1:0];

  reg_select_decode u_dec_ra (.idx(ir[RA_MSB:RA_LSB]), .onehot(ra_oh));
  reg_select_decode u_dec_rb (.idx(ir[RB_MSB:RB_LSB]), .onehot(rb_oh));
  reg_select_decode u_dec_rc (.idx(ir[RC_MSB:RC_LSB]), .onehot(rc_oh));

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= ST_RST;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RST: state <= ST_T0;
        ST_T0:  state <= ST_T1;
        ST_T1:  if (mem_ready) state <= ST_T2;
        ST_T2:  state <= ST_T3;
        ST_T3: begin
          case (cls)
            CL_ALU, CL_MUL, CL_DIV: state <= ST_T4;
            CL_HALT:                state <= ST_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
            CL_ILL: begin
              state   <= ST_HALT;
              illegal <= 1'b1;
            end
`endif
            default:                state <= ST_T0;
          endcase
        end
        ST_T4:  state <= ST_T5;
        ST_T5:  state <= (cls == CL_MUL || cls == CL_DIV) ? ST_T6 : ST_T0;
        ST_T6:  state <= ST_T0;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_RST;
      endcase
    end
  end

  // Decoded combinationally: the T1 handshake strobes must land in the same cycle mem_ready is seen.
  always_comb begin
    Rin = '0; Rout = '0; ALUop = '0;
    PCin = 1'b0; PCout = 1'b0; IRin = 1'b0; Yin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; HIin = 1'b0; HIout = 1'b0; LOin = 1'b0; LOout = 1'b0;
    Zlowin = 1'b0; Zhighin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    ALU_MUL = 1'b0; ALU_DIV = 1'b0; IncPC = 1'b0; Read = 1'b0; instr_done = 1'b0; halted = 1'b0;
    case (state)
      ST_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
      end
      ST_T1: begin
        Read = 1'b1;
        if (mem_ready) begin
          Zlowout = 1'b1; PCin = 1'b1; MDRin = 1'b1;
        end
      end
      ST_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      ST_T3: begin
        case (cls)
          CL_ALU, CL_MUL, CL_DIV: begin
            Rout = rb_oh; Yin = 1'b1;
          end
          CL_MFHI: begin
            HIout = 1'b1; Rin = ra_oh; instr_done = 1'b1;
          end
          CL_MFLO: begin
            LOout = 1'b1; Rin = ra_oh; instr_done = 1'b1;
          end
`ifdef CTRL_ILLEGAL_TRAP_EN
          CL_ILL: instr_done = 1'b0;
`endif
          default: instr_done = 1'b1;
        endcase
      end
      ST_T4: begin
        Rout   = rc_oh;
        Zlowin = 1'b1;
        if (cls == CL_MUL) begin
          ALU_MUL = 1'b1; Zhighin = 1'b1;
        end else if (cls == CL_DIV) begin
          ALU_DIV = 1'b1; Zhighin = 1'b1;
        end else begin
          ALUop = ir[OPC_LSB+3:OPC_LSB];
        end
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (cls == CL_MUL || cls == CL_DIV) begin
          LOin = 1'b1;
        end else begin
          Rin = ra_oh; instr_done = 1'b1;
        end
      end
      ST_T6: begin
        Zhighout = 1'b1; HIin = 1'b1; instr_done = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
